// File: rtl/adder_nbit_seq.sv
// Multi-cycle N-bit adder/subtractor: one SLICE-bit chunk per clock with the
// carry rippled through a register, valid/ready handshakes on both sides.
module adder_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("adder_nbit_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, s_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IDXW-1:0]  idx_q;

  logic [SLICE-1:0] slice_a, slice_b;
  logic [SLICE:0]   slice_sum;
  logic [WIDTH-1:0] res_d;
  logic             msb_cin;
  int               shamt;

  // Current slice add and the result register with that slice replaced.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    shamt     = int'(idx_q) * SLICE;
    slice_a   = SLICE'(a_q >> shamt);
    slice_b   = SLICE'(b_q >> shamt);
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
    res_d     = (res_q & ~(SLICE_MASK << shamt))
              | (WIDTH'(slice_sum[SLICE-1:0]) << shamt);
    // Carry into the slice MSB recovered from its sum bit: a ^ b ^ s.
    msb_cin   = slice_a[SLICE-1] ^ slice_b[SLICE-1] ^ slice_sum[SLICE-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so an aborted operation leaves nothing behind.
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= op_sub ? ~B : B;
            carry_q <= Cin;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          res_q   <= res_d;
          carry_q <= slice_sum[SLICE];
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            s_q     <= res_d;
            cout_q  <= slice_sum[SLICE];
            ovf_q   <= msb_cin ^ slice_sum[SLICE];
            idx_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_adder_nbit_seq.sv
// Scoreboard bench for adder_nbit_seq: driver pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares on output handshakes.
module tb_adder_nbit_seq;

  localparam int W  = 16;
  localparam int SL = 4;
  localparam int NS = W / SL;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, cin = 1'b0, op_sub = 1'b0;
  logic         out_valid, out_ready = 1'b1, cout, ovf;
  logic [W-1:0] a = '0, b = '0, s;

  logic         v1_in = 1'b0, v1_rdy, v1_out, c1, o1;
  logic [15:0]  s1;
  logic         v2_in = 1'b0, v2_rdy, v2_out, c2, o2;
  logic [31:0]  a2 = '0, b2 = '0, s2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;
  exp_t sbq[$];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        sub;
  } vec_t;

  vec_t vecs [8] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b1, 1'b1},
    '{16'h8000, 16'h0001, 1'b1, 1'b1},
    '{16'h0000, 16'h0000, 1'b0, 1'b1}
  };

  adder_nbit_seq #(.WIDTH(W), .SLICE(SL)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .S(s), .Cout(cout), .Ovf(ovf)
  );

  adder_nbit_seq #(.WIDTH(16), .SLICE(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1_in), .in_ready(v1_rdy),
    .A(a), .B(b), .Cin(cin), .op_sub(op_sub),
    .out_valid(v1_out), .out_ready(1'b1), .S(s1), .Cout(c1), .Ovf(o1)
  );

  adder_nbit_seq #(.WIDTH(32), .SLICE(8)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2_in), .in_ready(v2_rdy),
    .A(a2), .B(b2), .Cin(cin), .op_sub(op_sub),
    .out_valid(v2_out), .out_ready(1'b1), .S(s2), .Cout(c2), .Ovf(o2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: {ovf, cout, s[31:0]} from plain unsigned and signed arithmetic.
  function automatic logic [33:0] ref_model(input int w, input longint unsigned x,
                                            input longint unsigned y, input bit c, input bit sub);
    longint unsigned m, xx, yy, full;
    longint half, sx, sy, ci, ssum;
    logic [33:0] r;
    m    = (64'd1 << w) - 64'd1;
    xx   = x & m;
    yy   = sub ? (~y & m) : (y & m);
    full = xx + yy + longint'(c);
    half = longint'(64'd1 << (w - 1));
    sx   = longint'(xx);
    sy   = longint'(yy);
    if (sx >= half) sx = sx - 2 * half;
    if (sy >= half) sy = sy - 2 * half;
    ci   = longint'(c);
    ssum = sx + sy + ci;
    r        = '0;
    r[31:0]  = 32'(full & m);
    r[32]    = ((full >> w) & 64'd1) != 0;
    r[33]    = (ssum >= half) || (ssum < -half);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic sub);
    logic [33:0] r;
    exp_t e;
    int n;
    n = 0;
    a = x; b = y; cin = c; op_sub = sub; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
      if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    r      = ref_model(W, 64'(x), 64'(y), c, sub);
    e.s    = r[W-1:0];
    e.cout = r[32];
    e.ovf  = r[33];
    e.acc  = cyc;
    sbq.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      check("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  // Runs the 16/16 and 32/8 instances side by side and checks latency and result.
  task automatic cfg_run(input logic [15:0] x16, input logic [15:0] y16,
                         input logic [31:0] x32, input logic [31:0] y32,
                         input logic c, input logic sub);
    logic [33:0] r1, r2;
    int acc, lat1, lat2;
    r1 = ref_model(16, 64'(x16), 64'(y16), c, sub);
    r2 = ref_model(32, 64'(x32), 64'(y32), c, sub);
    a = x16; b = y16; a2 = x32; b2 = y32; cin = c; op_sub = sub;
    v1_in = 1'b1; v2_in = 1'b1;
    tick();
    acc = cyc;
    v1_in = 1'b0; v2_in = 1'b0;
    lat1 = -1; lat2 = -1;
    for (int n = 0; n < 10; n++) begin
      if (v1_out && lat1 < 0) begin
        lat1 = cyc - acc;
        check("s16_sum", 64'(s1), 64'(r1[15:0]));
        check("s16_cout_ovf", 64'({c1, o1}), 64'({r1[32], r1[33]}));
      end
      if (v2_out && lat2 < 0) begin
        lat2 = cyc - acc;
        check("w32_sum", 64'(s2), 64'(r2[31:0]));
        check("w32_cout_ovf", 64'({c2, o2}), 64'({r2[32], r2[33]}));
      end
      tick();
    end
    check("s16_latency", 64'(lat1), 64'd1);
    check("w32_latency", 64'(lat2), 64'd4);
  endtask

  // Monitor: compares the queue head whenever a result is presented, pops on handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    bit prev_valid;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_while_done", 64'(in_ready), 64'd0);
        if (sbq.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = sbq[0];
          check("sum", 64'(s), 64'(e.s));
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf", 64'(ovf), 64'(e.ovf));
          if (!prev_valid) check("latency", 64'(cyc - e.acc), 64'(NS));
          if (out_ready) void'(sbq.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s", 64'(s), 64'd0);
    check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed vectors: basic add, full ripple, overflow, subtract.
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub);
      if (i == 0) check("busy_in_ready", 64'(in_ready), 64'd0);
      drain();
    end

    // Backpressure with a competing request held during DONE.
    out_ready = 1'b0;
    send(16'h0123, 16'h0456, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid", 64'(out_valid), 64'd1);
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    repeat (3) begin
      tick();
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    check("bp_queue_empty", 64'(sbq.size()), 64'd0);
    send(16'h4000, 16'h3FFF, 1'b1, 1'b0);
    drain();

    // Reset two edges into ADD aborts the operation.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_s", 64'(s), 64'd0);
    check("abort_cout_ovf", 64'({cout, ovf}), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain();
    check("post_reset_s", 64'(s), 64'h0100);

    // Randomized traffic with random output backpressure.
    rand_rdy = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        out_ready = ($urandom_range(0, 2) != 0);
      end
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // Other configurations.
    cfg_run(16'h1234, 16'h4321, 32'h89AB1234, 32'h12344321, 1'b0, 1'b0);
    cfg_run(16'hFFFF, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    cfg_run(16'h8000, 16'h0001, 32'h80000000, 32'h00000001, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
